// File: rtl/sdram_loader_pkg.sv
// Shared constants for the SDRAM image path: framing markers, layer sizes,
// payload length and the SDRAM region base seen by the reader side.
package sdram_loader_pkg;

  localparam logic [31:0] START_MARK = 32'hF00B_F00B;
  localparam logic [31:0] STOP_MARK  = 32'hDEAD_F00B;

  localparam int IMSIZE  = 128;
  localparam int L0SIZE  = 2048;
  localparam int L1SIZE  = 256;
  localparam int L2SIZE  = 160;
  localparam int PAYLOAD = IMSIZE + L0SIZE + L1SIZE + L2SIZE;

  localparam logic [31:0] SDRAM_ADDR = 32'h0800_0000;

  // Width of the per-load byte counters; PAYLOAD must stay below 2**CNT_W.
  localparam int CNT_W = 12;

endpackage

// File: rtl/sdram_loader_marker_match.sv
// Four-byte shift window (oldest byte in the MSB) used for both framing markers.
// cand is the window as it would look with byte_in shifted in, so a marker is
// recognised in the same cycle its last byte is accepted.
module marker_match (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] cand
);

  logic [31:0] window;

  assign cand = {window[23:0], byte_in};

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   window <= '0;
    else if (clear) window <= '0;
    else if (shift) window <= cand;
  end

endmodule

// File: rtl/sdram_loader.sv
// Streams a framed image from a byte host into SDRAM over an Avalon write
// master: hunt for the start marker, write PAYLOAD bytes, check the trailer.
module sdram_loader
  import sdram_loader_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 8,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] BASE_ADDR = SDRAM_ADDR[MASTER_ADDRESSWIDTH-1:0],
  parameter int PAYLOAD             = sdram_loader_pkg::PAYLOAD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           s_valid,
  input  logic [7:0]                     s_data,
  output logic                           s_ready,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           load_done,
  output logic                           load_error,
  output logic [11:0]                    bytes_written
);

  typedef enum logic [1:0] {HUNT, LOAD, TRAIL, DRAIN} state_t;

  state_t            state, state_next;
  logic              wr_pending;
  logic [CNT_W-1:0]  byte_cnt;
  logic [31:0]       cand;
  logic              accept, retire;
  logic              start_hit, stop_hit;
  logic              last_payload, trail_full;
  logic              enter_load, trail_bad, drain_done, leaving;
  logic [CNT_W-1:0]  bw_after;

  assign accept       = s_valid && s_ready;
  assign retire       = wr_pending && !master_waitrequest;
  assign start_hit    = (cand == START_MARK);
  assign stop_hit     = (cand == STOP_MARK);
  assign last_payload = (byte_cnt == CNT_W'(PAYLOAD - 1));
  assign trail_full   = (byte_cnt == CNT_W'(3));

  assign leaving      = (state_next != state);
  assign enter_load   = (state == HUNT)  && (state_next == LOAD);
  assign trail_bad    = (state == TRAIL) && (state_next == HUNT);
  assign drain_done   = (state == DRAIN) && (state_next == HUNT);

  // A byte accepted while the previous write retires lands one address further on.
  assign bw_after     = bytes_written + CNT_W'(retire);

  assign master_write = wr_pending;
  assign master_read  = 1'b0;

  marker_match u_marker (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (leaving),
    .shift   (accept && (state == HUNT || state == TRAIL)),
    .byte_in (s_data),
    .cand    (cand)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:  if (accept && start_hit)    state_next = LOAD;
      LOAD:  if (accept && last_payload) state_next = TRAIL;
      TRAIL: if (accept && trail_full)   state_next = stop_hit ? DRAIN : HUNT;
      DRAIN: if (!wr_pending)            state_next = HUNT;
      default:                           state_next = HUNT;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b1;
    case (state)
      HUNT:    begin s_ready = 1'b1; busy = 1'b0; end
      LOAD:    s_ready = !wr_pending || !master_waitrequest;
      TRAIL:   s_ready = 1'b1;
      DRAIN:   s_ready = 1'b0;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pending       <= 1'b0;
      master_address   <= BASE_ADDR;
      master_writedata <= '0;
      byte_cnt         <= '0;
      bytes_written    <= '0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
    end else begin
      // Address and data only change on acceptance, so they hold during stalls.
      if (accept && state == LOAD) begin
        wr_pending       <= 1'b1;
        master_address   <= BASE_ADDR + MASTER_ADDRESSWIDTH'(bw_after);
        master_writedata <= DATAWIDTH'(s_data);
      end else if (retire) begin
        wr_pending <= 1'b0;
      end

      if (enter_load)  bytes_written <= '0;
      else if (retire) bytes_written <= bw_after;

      if (leaving)
        byte_cnt <= '0;
      else if (accept && (state == LOAD || state == TRAIL))
        byte_cnt <= byte_cnt + CNT_W'(1);

      if (enter_load) begin
        load_done  <= 1'b0;
        load_error <= 1'b0;
      end
      if (trail_bad)  load_error <= 1'b1;
      if (drain_done) load_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_loader.sv
// Randomised bench: byte streams are scored against a stream-level model of
// the framing rules; every retired write is compared in order.
module tb_sdram_loader;
  import sdram_loader_pkg::*;

  localparam int              AW   = 26;
  localparam int              PL   = PAYLOAD;
  localparam logic [AW-1:0]   BASE = SDRAM_ADDR[AW-1:0];

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic [AW-1:0] master_address;
  logic [7:0]    master_writedata;
  logic          master_write;
  logic          master_read;
  logic          master_waitrequest = 1'b0;
  logic          busy, load_done, load_error;
  logic [11:0]   bytes_written;

  sdram_loader #(
    .MASTER_ADDRESSWIDTH (AW),
    .DATAWIDTH           (8),
    .BASE_ADDR           (BASE),
    .PAYLOAD             (PL)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_write       (master_write),
    .master_read        (master_read),
    .master_waitrequest (master_waitrequest),
    .busy               (busy),
    .load_done          (load_done),
    .load_error         (load_error),
    .bytes_written      (bytes_written)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic [7:0] stream[$];
  wr_t        exp_q[$];
  bit         m_done  = 0;
  bit         m_error = 0;
  int         m_bw    = 0;

  function automatic void push_marker(input logic [31:0] m);
    for (int k = 3; k >= 0; k--) stream.push_back(m[8*k +: 8]);
  endfunction

  function automatic void push_payload(input bit rnd);
    for (int i = 0; i < PL; i++)
      stream.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256));
  endfunction

  // Walks the byte stream through hunt / payload / trailer phases.
  function automatic void model_run();
    logic [31:0] win;
    int          phase;
    int          cnt;
    win = '0; phase = 0; cnt = 0;
    foreach (stream[i]) begin
      case (phase)
        0: begin
          win = {win[23:0], stream[i]};
          if (win == START_MARK) begin
            phase = 1; cnt = 0; win = '0;
            m_done = 0; m_error = 0; m_bw = 0;
          end
        end
        1: begin
          exp_q.push_back(wr_t'{addr: BASE + AW'(cnt), data: stream[i]});
          cnt++;
          m_bw = cnt;
          if (cnt == PL) begin phase = 2; cnt = 0; win = '0; end
        end
        default: begin
          win = {win[23:0], stream[i]};
          cnt++;
          if (cnt == 4) begin
            if (win == STOP_MARK) m_done = 1;
            else                  m_error = 1;
            phase = 0; cnt = 0; win = '0;
          end
        end
      endcase
    end
  endfunction

  // ---------------- slave stall generator ----------------
  bit stall_en = 0;
  always @(posedge clk) begin
    #1;
    master_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // ---------------- write monitor ----------------
  int            wr_count = 0;
  bit            hold_v   = 0;
  logic [AW-1:0] hold_a;
  logic [7:0]    hold_d;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_v = 0;
    end else if (master_write) begin
      if (hold_v) begin
        check("stall_addr_held", 64'(master_address), 64'(hold_a));
        check("stall_data_held", 64'(master_writedata), 64'(hold_d));
      end
      if (!master_waitrequest) begin
        wr_t e;
        wr_count++;
        hold_v = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(master_address), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(master_address), 64'(e.addr));
          check("wr_data", 64'(master_writedata), 64'(e.data));
        end
      end else begin
        hold_v = 1;
        hold_a = master_address;
        hold_d = master_writedata;
      end
    end else begin
      if (hold_v) check("write_dropped_in_stall", 64'(master_write), 64'd1);
      hold_v = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_stream(input int abort_at);
    int  waited;
    bit  acc;
    for (int i = 0; i < stream.size(); i++) begin
      if (abort_at > 0 && wr_count >= abort_at) break;
      if ($urandom_range(0, 7) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = stream[i];
      waited  = 0;
      acc     = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        waited++;
        if (!acc && waited > 2000) begin
          check("accept_timeout", 64'(waited), 64'd0);
          s_valid = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || master_write) && n < 20000);
    if (n >= 20000) check("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic check_end(input string tag);
    @(negedge clk);
    check({tag, "_busy"},          64'(busy), 64'd0);
    check({tag, "_load_done"},     64'(load_done), 64'(m_done));
    check({tag, "_load_error"},    64'(load_error), 64'(m_error));
    check({tag, "_bytes_written"}, 64'(bytes_written), 64'(m_bw));
    check({tag, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_master_read"},   64'(master_read), 64'd0);
    check({tag, "_s_ready_hunt"},  64'(s_ready), 64'd1);
  endtask

  task automatic run_load(input string tag, input int abort_at);
    model_run();
    send_stream(abort_at);
    if (abort_at == 0) begin
      wait_idle();
      check_end(tag);
    end
  endtask

  task automatic build_load(input bit rnd, input logic [31:0] trailer);
    stream.delete();
    push_marker(START_MARK);
    push_payload(rnd);
    push_marker(trailer);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_master_write",   64'(master_write), 64'd0);
    check("rst_master_address", 64'(master_address), 64'(BASE));
    check("rst_writedata",      64'(master_writedata), 64'd0);
    check("rst_busy",           64'(busy), 64'd0);
    check("rst_load_done",      64'(load_done), 64'd0);
    check("rst_load_error",     64'(load_error), 64'd0);
    check("rst_bytes_written",  64'(bytes_written), 64'd0);
    check("rst_master_read",    64'(master_read), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Clean load, no stalls, payload i%256
    stall_en = 0;
    build_load(0, STOP_MARK);
    run_load("clean", 0);

    // Same stream with the slave stalling half the time
    stall_en = 1;
    build_load(0, STOP_MARK);
    run_load("stalled", 0);

    // Bad trailer, then a valid load
    build_load(1, 32'hDEAD_F00C);
    run_load("bad_trailer", 0);
    check("bad_trailer_flag", 64'(load_error), 64'd1);
    build_load(1, STOP_MARK);
    run_load("after_error", 0);

    // Garbage with a partial start pattern ahead of the real one
    stream.delete();
    begin
      logic [63:0] junk;
      junk = 64'h11F0_0BF0_F00B_F00B;
      for (int k = 7; k >= 0; k--) stream.push_back(junk[8*k +: 8]);
    end
    push_payload(1);
    push_marker(STOP_MARK);
    run_load("garbage", 0);

    // Start marker embedded in the payload is plain data
    build_load(1, STOP_MARK);
    for (int k = 0; k < 4; k++) stream[4 + 500 + k] = (k % 2 == 0) ? 8'hF0 : 8'h0B;
    run_load("inner_marker", 0);

    // Reset in the middle of a load while a write is outstanding
    wr_count = 0;
    build_load(1, STOP_MARK);
    run_load("abort", 1000);
    begin
      int n = 0;
      while (!master_write && n < 1000) begin @(negedge clk); n++; end
      check("abort_write_seen", 64'(master_write), 64'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("abort_master_write", 64'(master_write), 64'd0);
    check("abort_busy",         64'(busy), 64'd0);
    check("abort_load_done",    64'(load_done), 64'd0);
    check("abort_load_error",   64'(load_error), 64'd0);
    exp_q.delete();
    m_done = 0; m_error = 0; m_bw = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    build_load(1, STOP_MARK);
    run_load("post_reset", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_loader.md
SDRAM_LOADER -- requirements
Module: sdram_loader

Interface
REQ-001 The block SHALL have parameter MASTER_ADDRESSWIDTH, default 26: Avalon master address width.
REQ-002 The block SHALL have parameter DATAWIDTH, default 8: byte-wide data path.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0: first SDRAM byte written, MASTER_ADDRESSWIDTH bits wide. This is the reader's 32'h08000000 truncated to 26 bits.
REQ-004 The block SHALL have parameter PAYLOAD, default 2592: bytes per load (IMSIZE 128 + L0 2048 + L1 256 + L2 160).
REQ-005 The block SHALL have these ports:
- clk  in  1  single clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  host byte valid.
- s_data  in  8  host byte.
- s_ready  out  1  byte accepted when s_valid&&s_ready.
- master_address  out  MASTER_ADDRESSWIDTH  SDRAM write address.
- master_writedata  out  DATAWIDTH  SDRAM write byte.
- master_write  out  1  write request.
- master_read  out  1  tied 0.
- master_waitrequest  in  1  slave stall.
- busy  out  1  load in progress.
- load_done  out  1  last load completed cleanly (level).
- load_error  out  1  last load had a bad trailer (level).
- bytes_written  out  12  count of writes completed in the current or last load.

Function
REQ-006 The state machine SHALL have four states: HUNT, LOAD, TRAIL, DRAIN; busy SHALL be 0 only in HUNT.
REQ-007 HUNT: s_ready=1; the last 4 accepted bytes SHALL form a shift window, oldest byte MSB; a window equal to START_MARK 32'hF00BF00B SHALL go to LOAD, clear load_done, load_error and bytes_written, and set the write pointer to BASE_ADDR.
REQ-008 LOAD uses a single-entry write buffer; s_ready SHALL be (!wr_pending || !master_waitrequest), i.e. a byte may be accepted in the cycle the pending write retires.
REQ-009 An accepted byte SHALL set wr_pending, with master_write=1, master_writedata=byte and master_address=pointer the next cycle; all three SHALL stay stable while master_waitrequest=1.
REQ-010 A write SHALL retire on master_write && !master_waitrequest, incrementing the pointer and bytes_written by 1.
REQ-011 Acceptance of byte number PAYLOAD SHALL move the state to TRAIL, with the final write possibly still pending.
REQ-012 TRAIL: s_ready=1; after 4 accepted bytes the window SHALL be compared to STOP_MARK 32'hDEADF00B.
REQ-013 On a STOP_MARK match the state SHALL go to DRAIN; on a mismatch it SHALL go to HUNT with load_error=1.
REQ-014 DRAIN: s_ready=0; when wr_pending=0 the state SHALL go to HUNT with load_done=1 in the same transition.
REQ-015 Pending writes SHALL complete in every state; master_write SHALL never be asserted without wr_pending.
REQ-016 A START_MARK pattern inside the payload SHALL be treated as data, not re-detected.
REQ-017 The window SHALL be cleared on entry to HUNT and TRAIL, so markers never straddle phases.
REQ-018 master_address SHALL equal BASE_ADDR+bytes_written for every write, and SHALL NOT wrap within PAYLOAD.
REQ-019 master_read SHALL be constant 0.

Reset
REQ-020 On reset_n low, asynchronously, the state SHALL be HUNT and wr_pending=0. Outputs SHALL be: master_write=0, master_address=BASE_ADDR, master_writedata=0, busy=0, load_done=0, load_error=0, bytes_written=0, window=0.
REQ-021 Reset during LOAD SHALL drop master_write immediately; the partial load SHALL be abandoned with neither flag set.

Structure
REQ-022 A shared package SHALL hold START_MARK, STOP_MARK, L0SIZE, L1SIZE, L2SIZE, IMSIZE, PAYLOAD and SDRAM_ADDR, also used by sdram_interface; the loader state_t SHALL stay local.
REQ-023 One sub-module, marker_match, SHALL implement the 4-byte shift window with a clear input and a 32-bit compare output, instantiated once for both markers.

Verification
REQ-024 Bench: waitrequest=0; stream F0 0B F0 0B, 2592 bytes i%256, DE AD F0 0B -> 2592 writes at BASE_ADDR+i with data i%256, load_done=1, bytes_written=2592.
REQ-025 Bench: as REQ-024 with waitrequest randomly high 50% -> identical write sequence; address and data held during stalls; no dropped or duplicate bytes.
REQ-026 Bench: trailer DE AD F0 0C -> load_error=1, load_done=0, return to HUNT; a following valid load then succeeds.
REQ-027 Bench: garbage 11 F0 0B F0 F0 0B F0 0B before the payload -> load starts after the final 0B only; the first write carries the byte that follows.
REQ-028 Bench: reset_n pulsed low at write 1000 while master_write=1 -> master_write=0 within the reset cycle; the next full load succeeds from BASE_ADDR.
REQ-029 Bench: payload containing F0 0B F0 0B at offset 500 -> those bytes are written as data and the load completes normally.
